// File: rtl/switch_debounce_ctrl_if.sv
// Button inputs and debounced display controls for the TimeClock front-end.
// The design drives the outputs; the button source drives the raw inputs.
interface switch_debounce_ctrl_if;
    logic i_btn_mode;
    logic i_btn_onoff;
    logic o_modeSW;
    logic o_OnOffSW;
    logic o_clear;

    modport master (output i_btn_mode, i_btn_onoff,
                    input  o_modeSW, o_OnOffSW, o_clear);
    modport slave  (input  i_btn_mode, i_btn_onoff,
                    output o_modeSW, o_OnOffSW, o_clear);
endinterface

// File: rtl/switch_debounce_ctrl.sv
// Debounces the mode and on/off push-buttons into display level controls,
// plus a one-cycle clear pulse on a long on/off press.

module switch_debounce_lane #(
    parameter int unsigned STABLE_CNT = 20
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic tick,
    input  logic btn,
    output logic press_ev,
    output logic rel_ev,
    output logic held
);
    typedef enum logic [1:0] {IDLE, PRESS_W, PRESSED, REL_W} state_t;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      sync;
    logic            s_btn;

    assign s_btn = sync[1];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], btn};
            if (tick) begin
                case (state)
                    IDLE: if (s_btn) begin
                        state <= PRESS_W;
                        cnt   <= CW'(1);
                    end
                    PRESS_W: if (!s_btn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    PRESSED: if (!s_btn) begin
                        state <= REL_W;
                        cnt   <= CW'(1);
                    end
                    REL_W: if (s_btn) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Events fire in the tick cycle that completes the stable run.
    assign press_ev = tick && (state == PRESS_W) && s_btn  && (cnt == LAST);
    assign rel_ev   = tick && (state == REL_W)   && !s_btn && (cnt == LAST);
    assign held     = (state == PRESSED) || (state == REL_W);
endmodule

module switch_debounce_ctrl #(
    parameter int unsigned SAMPLE_DIV = 100_000,
    parameter int unsigned STABLE_CNT = 20,
    parameter int unsigned LONG_CNT   = 1000,
    parameter logic        RESET_MODE = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    switch_debounce_ctrl_if.slave bus
);
    localparam int NUM_LANES = 2;
    localparam int L_MODE    = 0;
    localparam int L_ONOFF   = 1;
    localparam int DW        = $clog2(SAMPLE_DIV);
    localparam int HW        = $clog2(LONG_CNT + 1);
    localparam logic [DW-1:0] TICK_AT = DW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);

    logic [DW-1:0]          div_cnt;
    logic                   tick;
    logic [NUM_LANES-1:0]   btn, press_ev, rel_ev, held;
    logic [HW-1:0]          hold, hold_nxt;
    logic                   mode_q, onoff_q, clear_q;

    assign tick = (div_cnt == TICK_AT);
    assign btn  = {bus.i_btn_onoff, bus.i_btn_mode};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)  div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        switch_debounce_lane #(.STABLE_CNT(STABLE_CNT)) u_lane (
            .gclk     (i_clk),
            .grst_n   (i_reset),
            .tick     (tick),
            .btn      (btn[g]),
            .press_ev (press_ev[g]),
            .rel_ev   (rel_ev[g]),
            .held     (held[g])
        );
    end

    // Hold time of the on/off button; saturation gives one clear per press.
    always_comb begin
        hold_nxt = hold;
        if (press_ev[L_ONOFF])
            hold_nxt = '0;
        else if (tick && held[L_ONOFF] && hold != HOLD_MAX)
            hold_nxt = hold + HW'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            hold    <= '0;
            mode_q  <= RESET_MODE;
            onoff_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            hold    <= hold_nxt;
            mode_q  <= mode_q ^ press_ev[L_MODE];
            clear_q <= (hold != HOLD_MAX) && (hold_nxt == HOLD_MAX);
            // A release that lands on or after the long-press threshold never toggles.
            onoff_q <= onoff_q ^ (rel_ev[L_ONOFF] && hold_nxt != HOLD_MAX);
        end
    end

    assign bus.o_modeSW  = mode_q;
    assign bus.o_OnOffSW = onoff_q;
    assign bus.o_clear   = clear_q;
endmodule
